// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the parametrised register file and its
// pending-write scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEFAULT   = 32;
  localparam int ADDR_W_DEFAULT   = 4;
  localparam int NUM_REGS_DEFAULT = 15;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-write counter for one register: saturating increment, flush to zero,
// and a one-cycle underflow flag when a decrement finds the count already zero.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + PEND_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - PEND_W'(1);
      else             underflow = 1'b1;
    end
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with same-cycle writeback bypass and a
// per-register pending-write scoreboard for ID-stage hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter int NUM_RD     = 2,
  parameter int PEND_W     = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     flush,
  output logic                     sb_err
);

  localparam logic [ADDR_W:0]   NUM_REGS_L = NUM_REGS[ADDR_W:0];
  localparam logic [PEND_W-1:0] CNT_MAX    = '1;

  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [PEND_W-1:0] cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;
  logic wb_valid, iss_valid, iss_sat;
  logic sb_err_d, sb_err_q;

  assign wb_valid  = wb_en & ({1'b0, wb_addr} < NUM_REGS_L);
  assign iss_valid = ({1'b0, iss_addr} < NUM_REGS_L);

  // A writeback retiring into a saturated register frees a slot this cycle.
  always_comb begin
    iss_sat = 1'b0;
    if (iss_valid) iss_sat = (cnt[iss_addr] == CNT_MAX);
    iss_ready = ~iss_sat | (wb_valid & (wb_addr == iss_addr));
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_valid) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = iss_en & iss_ready & iss_valid & (iss_addr == ADDR_W'(r));
    assign dec = wb_valid & (wb_addr == ADDR_W'(r));

    sb_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .inc       (inc),
      .dec       (dec),
      .cnt       (cnt[r]),
      .underflow (underflow[r])
    );
  end

  assign sb_err_d = sb_err_q | (|underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

  // A forwarded final write clears busy in the same cycle it is bypassed.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_k;
    logic [PEND_W-1:0] cnt_k;
    logic              valid, hit, busy_k;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      valid  = ({1'b0, addr} < NUM_REGS_L);
      hit    = (BYPASS != 0) & valid & wb_valid & (wb_addr == addr);
      cnt_k  = '0;
      data_k = '0;
      if (valid) begin
        cnt_k  = cnt[addr];
        data_k = hit ? wb_data : regs_q[addr];
      end
      busy_k = valid & (cnt_k != '0) & ~(hit & (cnt_k == PEND_W'(1)));
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_k;
    assign rd_busy[k]                  = busy_k;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default-parameter instance plus a
// 3-port, 64-bit, 16-register instance for the multi-port forwarding case.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_wb_en;
  logic [3:0]   a_wb_addr;
  logic [31:0]  a_wb_data;
  logic         a_iss_en;
  logic [3:0]   a_iss_addr;
  logic         a_iss_ready;
  logic         a_flush;
  logic         a_sb_err;

  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wb_en;
  logic [3:0]   b_wb_addr;
  logic [63:0]  b_wb_data;
  logic         b_iss_en;
  logic [3:0]   b_iss_addr;
  logic         b_iss_ready;
  logic         b_flush;
  logic         b_sb_err;

  int compared   = 0;
  int mismatched = 0;

  regfile_scoreboard dut_a (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .rd_busy   (a_rd_busy),
    .wb_en     (a_wb_en),
    .wb_addr   (a_wb_addr),
    .wb_data   (a_wb_data),
    .iss_en    (a_iss_en),
    .iss_addr  (a_iss_addr),
    .iss_ready (a_iss_ready),
    .flush     (a_flush),
    .sb_err    (a_sb_err)
  );

  regfile_scoreboard #(
    .DATA_W   (64),
    .NUM_REGS (16),
    .NUM_RD   (3)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .rd_busy   (b_rd_busy),
    .wb_en     (b_wb_en),
    .wb_addr   (b_wb_addr),
    .wb_data   (b_wb_data),
    .iss_en    (b_iss_en),
    .iss_addr  (b_iss_addr),
    .iss_ready (b_iss_ready),
    .flush     (b_flush),
    .sb_err    (b_sb_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wb_en, input logic [3:0] wb_addr,
                               input logic [31:0] wb_data, input logic iss_en,
                               input logic [3:0] iss_addr, input logic flush);
    a_wb_en    = wb_en;
    a_wb_addr  = wb_addr;
    a_wb_data  = wb_data;
    a_iss_en   = iss_en;
    a_iss_addr = iss_addr;
    a_flush    = flush;
    #1;
  endtask

  task automatic setReads(input logic [3:0] p0, input logic [3:0] p1);
    a_rd_addr = {p1, p0};
    #1;
  endtask

  task automatic advanceClock;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    b_rd_addr  = {4'd15, 4'd15, 4'd0};
    b_wb_en    = 1'b0;
    b_wb_addr  = '0;
    b_wb_data  = '0;
    b_iss_en   = 1'b0;
    b_iss_addr = '0;
    b_flush    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    setReads(0, 14);

    // Reset values
    checkOutput("rst_rd0",       a_rd_data[31:0],  0);
    checkOutput("rst_rd14",      a_rd_data[63:32], 14);
    checkOutput("rst_busy",      a_rd_busy,        0);
    checkOutput("rst_iss_ready", a_iss_ready,      1);
    checkOutput("rst_sb_err",    a_sb_err,         0);
    checkOutput("b_rst_r15",     b_rd_data[127:64], 15);
    checkOutput("b_rst_busy",    b_rd_busy,        0);
    checkOutput("b_rst_ready",   b_iss_ready,      1);
    checkOutput("b_rst_sb_err",  b_sb_err,         0);
    #20;
    rst = 1'b0;
    advanceClock();

    // Same-cycle bypass, then registered value
    setReads(3, 4);
    applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("bypass_rd0",    a_rd_data[31:0],  32'hDEADBEEF);
    checkOutput("bypass_rd1",    a_rd_data[63:32], 4);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("written_rd0",   a_rd_data[31:0],  32'hDEADBEEF);
    checkOutput("written_busy",  a_rd_busy,        0);
    checkOutput("idle_wb_err",   a_sb_err,         1);
    applyStimulus(1, 14, 32'h1234, 0, 0, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setReads(14, 3);
    checkOutput("written_r14",   a_rd_data[31:0],  32'h1234);

    // Asynchronous reset mid-cycle restores index values immediately
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      setReads(4'(i), 15);
      checkOutput($sformatf("midrst_rd_%0d", i), a_rd_data[31:0],
                  (i < 15) ? 64'(i) : 64'd0);
    end
    checkOutput("midrst_rd15",   a_rd_data[63:32], 0);
    checkOutput("midrst_busy",   a_rd_busy,        0);
    checkOutput("midrst_sb_err", a_sb_err,         0);
    advanceClock();
    rst = 1'b0;
    advanceClock();

    // Two issues to r5, retired by two writebacks
    setReads(5, 5);
    applyStimulus(0, 0, 0, 1, 5, 0);
    checkOutput("r5_iss_ready",  a_iss_ready,      1);
    advanceClock();
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r5_busy_2",     a_rd_busy[0],     1);
    applyStimulus(1, 5, 32'h55, 0, 0, 0);
    checkOutput("r5_wb1_busy",   a_rd_busy[0],     1);
    checkOutput("r5_wb1_data",   a_rd_data[31:0],  32'h55);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r5_busy_1",     a_rd_busy[0],     1);
    checkOutput("r5_data_1",     a_rd_data[31:0],  32'h55);
    applyStimulus(1, 5, 32'h56, 0, 0, 0);
    checkOutput("r5_wb2_busy",   a_rd_busy[0],     0);
    checkOutput("r5_wb2_data",   a_rd_data[31:0],  32'h56);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r5_idle_busy",  a_rd_busy[0],     0);
    checkOutput("r5_idle_data",  a_rd_data[31:0],  32'h56);
    checkOutput("r5_no_err",     a_sb_err,         0);

    // Saturation of r2
    setReads(2, 2);
    applyStimulus(0, 0, 0, 1, 2, 0);
    advanceClock();
    advanceClock();
    advanceClock();
    checkOutput("r2_sat_ready",   a_iss_ready,     0);
    advanceClock();
    checkOutput("r2_4th_ignored", a_iss_ready,     0);
    checkOutput("r2_sat_busy",    a_rd_busy[0],    1);
    applyStimulus(1, 2, 32'h22, 1, 2, 0);
    checkOutput("r2_sat_wb_ready", a_iss_ready,    1);
    advanceClock();
    applyStimulus(0, 0, 0, 1, 2, 0);
    checkOutput("r2_still_sat",   a_iss_ready,     0);
    applyStimulus(1, 2, 32'h23, 0, 2, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 2, 0);
    checkOutput("r2_unsat_ready", a_iss_ready,     1);
    checkOutput("r2_unsat_busy",  a_rd_busy[0],    1);

    // Underflow on r7 still writes the data
    applyStimulus(1, 7, 32'h77, 0, 0, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setReads(7, 2);
    checkOutput("r7_sb_err",      a_sb_err,        1);
    checkOutput("r7_data",        a_rd_data[31:0], 32'h77);

    // Flush clears every pending count but keeps data and sb_err
    applyStimulus(0, 0, 0, 1, 1, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 1, 4, 0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setReads(1, 4);
    checkOutput("pre_flush_busy", a_rd_busy,       2'b11);
    applyStimulus(0, 0, 0, 0, 0, 1);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flush_busy_r1r4", a_rd_busy,      2'b00);
    setReads(2, 5);
    checkOutput("flush_busy_r2",  a_rd_busy,       2'b00);
    checkOutput("flush_data_r5",  a_rd_data[63:32], 32'h56);
    checkOutput("flush_sb_err",   a_sb_err,        1);
    applyStimulus(0, 0, 0, 1, 15, 0);
    checkOutput("iss_addr15_ready", a_iss_ready,   1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Three-port instance: two ports forward a write to r15
    b_wb_en   = 1'b1;
    b_wb_addr = 4'd0;
    b_wb_data = 64'h0123456789ABCDEF;
    advanceClock();
    b_wb_addr = 4'd15;
    b_wb_data = 64'hCAFEF00D12345678;
    b_rd_addr = {4'd15, 4'd15, 4'd0};
    #1;
    checkOutput("b_port0_r0",     b_rd_data[63:0],    64'h0123456789ABCDEF);
    checkOutput("b_port1_fwd",    b_rd_data[127:64],  64'hCAFEF00D12345678);
    checkOutput("b_port2_fwd",    b_rd_data[191:128], 64'hCAFEF00D12345678);
    advanceClock();
    b_wb_en = 1'b0;
    #1;
    checkOutput("b_port1_stored", b_rd_data[127:64],  64'hCAFEF00D12345678);
    checkOutput("b_port0_stored", b_rd_data[63:0],    64'h0123456789ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 15-entry register file: configurable data width, depth and number of read ports.
- Adds same-cycle writeback bypass and a per-register pending-write scoreboard for hazard detection.
- Sits between ID (reads, issue marks) and WB (writeback, pending clear) in the pipelined core.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width.
- NUM_REGS, 15, implemented registers (must be <= 2**ADDR_W).
- NUM_RD, 2, number of combinational read ports.
- PEND_W, 2, width of each per-register pending counter.
- BYPASS, 1, 1 = read of a register being written this cycle returns wb_data.
- INIT_INDEX, 1, 1 = reset value of reg[i] is i; 0 = all zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  port k's register has an outstanding write.
- wb_en  in  1  writeback enable.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- iss_en  in  1  issue: mark iss_addr as pending-write.
- iss_addr  in  ADDR_W  issued destination.
- iss_ready  out  1  iss_addr's pending counter is not saturated.
- flush  in  1  clear all pending counters (data untouched).
- sb_err  out  1  sticky: a writeback arrived for a register whose count was 0.

Behaviour:
- Reset (async, any time):
  - reg[i] = INIT_INDEX ? i : 0.
  - All pending counters = 0 and sb_err = 0.
  - Outputs settle combinationally: rd_busy = 0, iss_ready = 1.
- Write path:
  - On posedge with wb_en and wb_addr < NUM_REGS, reg[wb_addr] <= wb_data.
  - wb_addr >= NUM_REGS: write ignored; no counter change; no error.
- Read path (per port k, combinational):
  - rd_addr >= NUM_REGS: rd_data = 0, rd_busy = 0.
  - BYPASS=1, wb_en, and wb_addr == rd_addr (valid): rd_data = wb_data.
  - Otherwise rd_data = reg[rd_addr].
- Busy:
  - rd_busy[k] = (cnt[rd_addr] != 0).
  - Exception: BYPASS=1, wb_en, wb_addr == rd_addr and cnt == 1 (final write forwarded now) gives rd_busy[k] = 0.
- Scoreboard, per register r, next cnt[r]:
  - flush=1: 0 for all r; overrides iss and wb this cycle. wb data write still occurs.
  - inc = iss_en & iss_ready & iss_addr==r (valid addr); dec = wb_en & wb_addr==r.
  - inc & dec: unchanged.
  - inc only: cnt+1.
  - dec only: cnt-1 if cnt>0; else stays 0 and sb_err <= 1.
- iss_ready = (iss_addr >= NUM_REGS) | (cnt[iss_addr] != 2**PEND_W-1).
  - Exception: ready also when saturated but a dec to the same register occurs this cycle.
  - iss_en while !iss_ready: ignored, no state change.
- sb_err: cleared only by rst; not cleared by flush.
- Latency:
  - Write visible to non-bypassed reads the cycle after the posedge.
  - Counter changes visible on rd_busy/iss_ready the cycle after.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, reg_addr_t and reg_data_t typedefs, NUM_REGS_DEFAULT = 15.
- One sub-module: sb_counter (single saturating up/down counter with flush and underflow flag), instantiated NUM_REGS times.
- Read-port muxing stays in the top in a generate loop.

Test Plan:
- Reset: assert rst mid-cycle after writes; read ports on 0..14 -> rd_data = 0..14 immediately, rd_busy = 0, sb_err = 0; addr 15 -> data 0.
- Write/bypass: wb_en, wb_addr=3, wb_data=0xDEADBEEF, rd_addr0=3 same cycle -> rd_data0 = 0xDEADBEEF (BYPASS=1) or 3 (BYPASS=0); next cycle = 0xDEADBEEF either way.
- Scoreboard: iss r5 in two cycles -> rd_busy on r5 = 1.
  - First wb r5 -> still busy.
  - Second wb r5 -> rd_busy = 0 in the same cycle (bypass), and 0 thereafter.
- Saturation (PEND_W=2): issue r2 three times -> iss_ready = 0.
  - 4th iss_en ignored (count stays 3).
  - iss+wb r2 same cycle -> count stays 3; a following wb alone -> iss_ready = 1.
- Underflow/flush: wb r7 with count 0 -> sb_err = 1, reg[7] updated.
  - Issue r1, r4, then flush -> all rd_busy = 0, sb_err stays 1.
- Multi-port (NUM_RD=3, DATA_W=64, NUM_REGS=16): simultaneous reads of r0, r15, r15 with a wb to r15 -> ports 1,2 forward wb_data; port 0 returns reg[0].
